// File: rtl/clock_set_ctrl_if.sv
// Button, running-time and load/status bundle between the time-setting controller and its neighbours.
// No storage in the interface itself; the timing is set by whichever module drives each signal.
// No handshake: the buttons are single-cycle pulses and time_ow is a plain strobe.
interface clock_set_ctrl_if;
  // debounced one-cycle button pulses
  logic        btn_mode;
  logic        btn_inc;
  logic        btn_dec;
  logic        btn_cancel;

  // BCD running time from the clock datapath
  logic [3:0]  cur_hr_10s;
  logic [3:0]  cur_hr_1s;
  logic [3:0]  cur_min_10s;
  logic [3:0]  cur_min_1s;
  logic [3:0]  cur_sec_10s;
  logic [3:0]  cur_sec_1s;

  // overwrite port to the clock and status to the display mux
  logic        time_ow;
  logic [16:0] time_in;
  logic [1:0]  edit_field;
  logic        setting;
  logic        blink;

  // controller side
  modport slave (
    input  btn_mode, btn_inc, btn_dec, btn_cancel,
    input  cur_hr_10s, cur_hr_1s, cur_min_10s, cur_min_1s, cur_sec_10s, cur_sec_1s,
    output time_ow, time_in, edit_field, setting, blink
  );

  // environment side (buttons, clock datapath, display)
  modport master (
    output btn_mode, btn_inc, btn_dec, btn_cancel,
    output cur_hr_10s, cur_hr_1s, cur_min_10s, cur_min_1s, cur_sec_10s, cur_sec_1s,
    input  time_ow, time_in, edit_field, setting, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Button-driven time-setting FSM: capture the running time, edit hr/min/sec, commit via time_ow/time_in.
// Button effects land on the next edge; commit loads time_in at LOAD entry, then time_ow is high for OW_CYCLES.
// No backpressure: every button pulse is acted on or dropped in its own cycle (all ignored in LOAD).
module clock_set_ctrl #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int TIMEOUT_SEC = 30,
  parameter int OW_CYCLES   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  clock_set_ctrl_if.slave bus
);

  // Inactivity timeout: counts TIMEOUT_SEC*CLK_FREQ cycles, aborts on the edge after the last count.
  localparam int TO_CYCLES = (TIMEOUT_SEC * CLK_FREQ < 2) ? 2 : TIMEOUT_SEC * CLK_FREQ;
  localparam int TO_W      = $clog2(TO_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_CYCLES - 1);

  // Blink half-period: CLK_FREQ/4 cycles gives a 2 Hz blink.
  localparam int BL_HALF = (CLK_FREQ / 4 < 2) ? 2 : CLK_FREQ / 4;
  localparam int BL_W    = $clog2(BL_HALF);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BL_HALF - 1);

  // Overwrite strobe length; at least one cycle.
  localparam int OW_N  = (OW_CYCLES < 1) ? 1 : OW_CYCLES;
  localparam int OW_W  = $clog2(OW_N + 1);
  localparam logic [OW_W-1:0] OW_MAX = OW_W'(OW_N);

  // FSM encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SET_HR  = 3'd1;
  localparam logic [2:0] ST_SET_MIN = 3'd2;
  localparam logic [2:0] ST_SET_SEC = 3'd3;
  localparam logic [2:0] ST_LOAD    = 3'd4;

  logic [2:0]      state;
  logic [2:0]      nxt_state;
  logic [4:0]      hr;
  logic [5:0]      min;
  logic [5:0]      sec;
  logic [TO_W-1:0] to_cnt;
  logic [BL_W-1:0] bl_cnt;
  logic [OW_W-1:0] ow_cnt;
  logic            blink_q;
  logic            time_ow_q;
  logic [16:0]     time_in_q;

  logic            in_set;
  logic            nxt_in_set;
  logic            btn_any;
  logic            up;
  logic            dn;
  logic            edit_en;
  logic            to_expire;
  logic [7:0]      cap_hr_raw;
  logic [7:0]      cap_min_raw;
  logic [7:0]      cap_sec_raw;
  logic [4:0]      cap_hr;
  logic [5:0]      cap_min;
  logic [5:0]      cap_sec;
  logic [5:0]      hr_step;
  logic [5:0]      min_step;
  logic [5:0]      sec_step;

  // One-step wrap-around adjust; inc and dec together cancel out.
  function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] top,
                                      input logic inc, input logic dec);
    logic [5:0] r;
    r = v;
    if (inc && !dec) begin
      r = (v >= top) ? 6'd0 : v + 6'd1;
    end else if (dec && !inc) begin
      r = (v == 6'd0 || v > top) ? top : v - 6'd1;
    end
    return r;
  endfunction

  // BCD-to-binary capture with out-of-range values forced to zero.
  always_comb begin
    cap_hr_raw  = {4'd0, bus.cur_hr_10s}  * 8'd10 + {4'd0, bus.cur_hr_1s};
    cap_min_raw = {4'd0, bus.cur_min_10s} * 8'd10 + {4'd0, bus.cur_min_1s};
    cap_sec_raw = {4'd0, bus.cur_sec_10s} * 8'd10 + {4'd0, bus.cur_sec_1s};
    cap_hr      = (cap_hr_raw  > 8'd23) ? 5'd0 : cap_hr_raw[4:0];
    cap_min     = (cap_min_raw > 8'd59) ? 6'd0 : cap_min_raw[5:0];
    cap_sec     = (cap_sec_raw > 8'd59) ? 6'd0 : cap_sec_raw[5:0];
  end

  // Candidate field values after an inc/dec in the active field.
  always_comb begin
    up       = bus.btn_inc;
    dn       = bus.btn_dec;
    hr_step  = step({1'b0, hr}, 6'd23, up, dn);
    min_step = step(min, 6'd59, up, dn);
    sec_step = step(sec, 6'd59, up, dn);
  end

  // Next-state decode: cancel beats mode beats inc/dec; timeout only when no button is pressed.
  always_comb begin
    in_set    = (state == ST_SET_HR) || (state == ST_SET_MIN) || (state == ST_SET_SEC);
    btn_any   = bus.btn_mode | bus.btn_inc | bus.btn_dec | bus.btn_cancel;
    edit_en   = in_set && !bus.btn_cancel && !bus.btn_mode && (bus.btn_inc || bus.btn_dec);
    to_expire = in_set && !btn_any && (to_cnt == TO_MAX);
    nxt_state = state;
    case (state)
      ST_IDLE: begin
        if (bus.btn_mode) nxt_state = ST_SET_HR;
      end
      ST_SET_HR, ST_SET_MIN, ST_SET_SEC: begin
        if (bus.btn_cancel) begin
          nxt_state = ST_IDLE;
        end else if (bus.btn_mode) begin
          case (state)
            ST_SET_HR:  nxt_state = ST_SET_MIN;
            ST_SET_MIN: nxt_state = ST_SET_SEC;
            default:    nxt_state = ST_LOAD;
          endcase
        end else if (to_expire) begin
          nxt_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (ow_cnt == OW_MAX) nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
    nxt_in_set = (nxt_state == ST_SET_HR) || (nxt_state == ST_SET_MIN) ||
                 (nxt_state == ST_SET_SEC);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt_state;
  end

  // Edit registers: captured once on edit start, then touched only by inc/dec of the active field.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hr  <= 5'd0;
      min <= 6'd0;
      sec <= 6'd0;
    end else if (state == ST_IDLE && bus.btn_mode) begin
      hr  <= cap_hr;
      min <= cap_min;
      sec <= cap_sec;
    end else if (edit_en) begin
      case (state)
        ST_SET_HR:  hr  <= hr_step[4:0];
        ST_SET_MIN: min <= min_step;
        default:    sec <= sec_step;
      endcase
    end
  end

  // Inactivity counter: restarted by edit entry and by any button while editing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (!in_set || btn_any || to_expire) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Commit: time_in loads on LOAD entry, time_ow rises one edge later so time_in is settled first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      time_in_q <= 17'd0;
      time_ow_q <= 1'b0;
      ow_cnt    <= '0;
    end else if (state != ST_LOAD) begin
      time_ow_q <= 1'b0;
      ow_cnt    <= '0;
      if (nxt_state == ST_LOAD) time_in_q <= {hr, min, sec};
    end else if (ow_cnt == OW_MAX) begin
      time_ow_q <= 1'b0;
      ow_cnt    <= '0;
    end else begin
      time_ow_q <= 1'b1;
      ow_cnt    <= ow_cnt + 1'b1;
    end
  end

  // Blink: forced on at field entry and after each edit, free-running toggle while editing, off otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_q <= 1'b0;
      bl_cnt  <= '0;
    end else if (!nxt_in_set) begin
      blink_q <= 1'b0;
      bl_cnt  <= '0;
    end else if (nxt_state != state || edit_en) begin
      blink_q <= 1'b1;
      bl_cnt  <= '0;
    end else if (bl_cnt == BL_MAX) begin
      blink_q <= ~blink_q;
      bl_cnt  <= '0;
    end else begin
      bl_cnt  <= bl_cnt + 1'b1;
    end
  end

  // Status and load outputs; edit_field decodes straight from the state register.
  always_comb begin
    case (state)
      ST_SET_HR:  bus.edit_field = 2'd1;
      ST_SET_MIN: bus.edit_field = 2'd2;
      ST_SET_SEC: bus.edit_field = 2'd3;
      default:    bus.edit_field = 2'd0;
    endcase
    bus.setting = in_set;
    bus.blink   = blink_q;
    bus.time_ow = time_ow_q;
    bus.time_in = time_in_q;
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with CLK_FREQ=8, TIMEOUT_SEC=2, OW_CYCLES=4.
// Expected commits are queued at stimulus time; a negedge monitor pops them when time_ow falls.
// Status outputs are checked directly #1 after the clock edge.
module tb_clock_set_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(.CLK_FREQ(8), .TIMEOUT_SEC(2), .OW_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] exp_q[$];

  function automatic logic [16:0] pk(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic m, input logic i, input logic d, input logic c);
    bus.btn_mode = m; bus.btn_inc = i; bus.btn_dec = d; bus.btn_cancel = c;
    tick(1);
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; bus.btn_cancel = 1'b0;
  endtask

  task automatic set_time(input int h10, input int h1, input int m10, input int m1,
                          input int s10, input int s1);
    bus.cur_hr_10s  = 4'(h10); bus.cur_hr_1s  = 4'(h1);
    bus.cur_min_10s = 4'(m10); bus.cur_min_1s = 4'(m1);
    bus.cur_sec_10s = 4'(s10); bus.cur_sec_1s = 4'(s1);
  endtask

  // Commit monitor: tracks each time_ow pulse and scores it against the queue when it ends.
  logic        mon_prev;
  int          mon_len;
  logic [16:0] mon_val;
  logic [16:0] mon_last_ti;
  logic        mon_bad;
  initial begin
    mon_prev = 1'b0; mon_len = 0; mon_val = '0; mon_last_ti = '0; mon_bad = 1'b0;
  end

  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst_n) begin
      mon_prev = 1'b0;
      mon_len  = 0;
      mon_bad  = 1'b0;
    end else begin
      if (bus.time_ow) begin
        if (!mon_prev) begin
          mon_val = bus.time_in;
          mon_len = 1;
          mon_bad = (bus.time_in != mon_last_ti);
        end else begin
          mon_len++;
          if (bus.time_in != mon_val) mon_bad = 1'b1;
        end
      end else if (mon_prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL commit_unexpected: got time_in=%h len=%0d, want no commit", mon_val, mon_len);
        end else begin
          e = exp_q.pop_front();
          if (mon_val != e || mon_len != 4 || mon_bad || bus.time_in != e) begin
            bad++;
            $display("FAIL commit: got time_in=%h len=%0d unstable=%0d held=%h, want time_in=%h len=4 stable",
                     mon_val, mon_len, mon_bad, bus.time_in, e);
          end
        end
      end
      mon_prev    = bus.time_ow;
      mon_last_ti = bus.time_in;
    end
  end

  initial begin
    int n;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; bus.btn_cancel = 1'b0;
    set_time(1, 2, 3, 4, 5, 6);
    tick(2);
    check("rst_time_ow", int'(bus.time_ow), 0);
    check("rst_time_in", int'(bus.time_in), 0);
    check("rst_edit_field", int'(bus.edit_field), 0);
    check("rst_blink", int'(bus.blink), 0);
    rst_n = 1'b1;
    tick(1);

    // Reset in the middle of a commit.
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    n = 0;
    while (!bus.time_ow && n < 10) begin
      tick(1);
      n++;
    end
    check("load_ow_rise", int'(bus.time_ow), 1);
    rst_n = 1'b0;
    tick(1);
    check("midload_rst_time_ow", int'(bus.time_ow), 0);
    check("midload_rst_time_in", int'(bus.time_in), 0);
    check("midload_rst_edit_field", int'(bus.edit_field), 0);
    check("midload_rst_setting", int'(bus.setting), 0);
    check("midload_rst_blink", int'(bus.blink), 0);
    rst_n = 1'b1;
    tick(8);

    // 12:34:56 -> hr+2, min-1 -> 14:33:56.
    set_time(1, 2, 3, 4, 5, 6);
    press(1, 0, 0, 0);
    check("edit_hr_field", int'(bus.edit_field), 1);
    check("edit_hr_setting", int'(bus.setting), 1);
    press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    check("edit_min_field", int'(bus.edit_field), 2);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    check("edit_sec_field", int'(bus.edit_field), 3);
    exp_q.push_back(pk(14, 33, 56));
    press(1, 0, 0, 0);
    check("load_field", int'(bus.edit_field), 0);
    check("load_setting", int'(bus.setting), 0);
    tick(8);
    check("commit1_held", int'(bus.time_in), int'(pk(14, 33, 56)));
    check("commit1_ow_low", int'(bus.time_ow), 0);

    // Wrap-around from 23:59:00, inc+dec no-op, running time changing mid-edit.
    set_time(2, 3, 5, 9, 0, 0);
    press(1, 0, 0, 0);
    set_time(0, 1, 0, 2, 0, 3);
    press(0, 1, 0, 0);
    press(0, 1, 1, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    exp_q.push_back(pk(0, 0, 59));
    press(1, 0, 0, 0);
    tick(8);
    check("commit2_held", int'(bus.time_in), int'(pk(0, 0, 59)));

    // Cancel (together with mode, cancel wins) in SET_MIN after edits.
    set_time(1, 2, 3, 4, 5, 6);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    check("cancel_pre_field", int'(bus.edit_field), 2);
    press(1, 0, 0, 1);
    check("cancel_field", int'(bus.edit_field), 0);
    check("cancel_blink", int'(bus.blink), 0);
    tick(8);
    check("cancel_ow", int'(bus.time_ow), 0);
    check("cancel_time_in", int'(bus.time_in), int'(pk(0, 0, 59)));

    // Timeout in SET_SEC after 16 idle cycles, restarted by an inc at cycle 10.
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    tick(15);
    check("to_cycle15_field", int'(bus.edit_field), 3);
    tick(1);
    check("to_cycle16_field", int'(bus.edit_field), 0);
    check("to_cycle16_ow", int'(bus.time_ow), 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    tick(9);
    press(0, 1, 0, 0);
    tick(15);
    check("to_restart15_field", int'(bus.edit_field), 3);
    tick(1);
    check("to_restart16_field", int'(bus.edit_field), 0);
    tick(6);
    check("to_time_in", int'(bus.time_in), int'(pk(0, 0, 59)));

    // Invalid capture 27:65:07 and the blink pattern.
    set_time(2, 7, 6, 5, 0, 7);
    press(1, 0, 0, 0);
    check("blink_entry", int'(bus.blink), 1);
    tick(1);
    check("blink_c1", int'(bus.blink), 1);
    tick(1);
    check("blink_c2", int'(bus.blink), 0);
    press(0, 1, 0, 0);
    check("blink_inc_force", int'(bus.blink), 1);
    tick(1);
    check("blink_inc_c1", int'(bus.blink), 1);
    tick(1);
    check("blink_inc_c2", int'(bus.blink), 0);
    press(1, 0, 0, 0);
    check("blink_min_entry", int'(bus.blink), 1);
    check("blink_min_field", int'(bus.edit_field), 2);
    press(1, 0, 0, 0);
    exp_q.push_back(pk(1, 0, 7));
    press(1, 0, 0, 0);
    check("blink_load_off", int'(bus.blink), 0);
    tick(8);
    check("invalid_commit_held", int'(bus.time_in), int'(pk(1, 0, 7)));

    tick(4);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1);
  end
endmodule
